jk_updown_counter: RTL and testbench

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_cell.sv | 39 +++
 rtl/jk_updown_counter.sv | 97 +++++++++
 tb/tb_jk_updown_counter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// JK drive encodings shared by the counter steering logic and the per-bit cells.
// The mode value is {j, k}.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLEAR  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_mode_e;

    // Drive that forces a cell to a known value regardless of its current state.
    function automatic jk_mode_e jk_force(input logic val);
        return val ? JK_SET : JK_CLEAR;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to 0.
// qb is the complement of the stored bit.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case (jk_mode_e'({j, k}))
            JK_HOLD:   q_d = q_q;
            JK_CLEAR:  q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
            default:   q_d = q_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-MOD up/down counter whose state lives entirely in one jk_cell per bit.
// This level only steers j/k, registers the out-of-range-load flag and forms tc.
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MOD);

    logic             load_bad;
    logic             wrap;
    logic [WIDTH-1:0] nxt;
    jk_mode_e         mode_d [WIDTH];
    logic [WIDTH-1:0] j_d;
    logic [WIDTH-1:0] k_d;
    logic             err_d;
    logic             err_q;

    assign load_bad = ({1'b0, d} >= MOD_X);

    always_comb begin
        nxt  = q;
        wrap = 1'b0;
        if (up) begin
            if (q == MAX_Q) begin
                nxt  = '0;
                wrap = 1'b1;
            end else begin
                nxt = q + WIDTH'(1);
            end
        end else begin
            if (q == '0) begin
                nxt  = MAX_Q;
                wrap = 1'b1;
            end else begin
                nxt = q - WIDTH'(1);
            end
        end
    end

    // Wrap forces every bit with set/clear; ordinary steps toggle only changing bits.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            mode_d[i] = JK_HOLD;
            if (load) begin
                mode_d[i] = load_bad ? JK_CLEAR : jk_force(d[i]);
            end else if (en) begin
                if (wrap) begin
                    mode_d[i] = jk_force(nxt[i]);
                end else if (nxt[i] != q[i]) begin
                    mode_d[i] = JK_TOGGLE;
                end
            end
            j_d[i] = mode_d[i][1];
            k_d[i] = mode_d[i][0];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_d[g]),
            .k   (k_d[g]),
            .q   (q[g]),
            .qb  (qb[g])
        );
    end

    assign err_d = load & load_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
    assign tc  = ~rst & en & ~load & ((up & (q == MAX_Q)) | (~up & (q == '0)));

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed and random checks of jk_updown_counter (WIDTH=4, MOD=10) against
// an arithmetic modulo-counter reference model.
module tb_jk_updown_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;
    logic             err;

    int checks = 0;
    int errors = 0;
    int m_q    = 0;
    int m_err  = 0;

    jk_updown_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .up   (up),
        .load (load),
        .d    (d),
        .q    (q),
        .qb   (qb),
        .tc   (tc),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs for one edge; tc checked before the edge, state after.
    task automatic step(input bit r, input bit l, input bit e, input bit u, input int dv);
        int exp_tc;
        rst  = r;
        load = l;
        en   = e;
        up   = u;
        d    = dv[WIDTH-1:0];
        #1;
        exp_tc = (!r && !l && e && ((u && m_q == MOD - 1) || (!u && m_q == 0))) ? 1 : 0;
        chk("tc", {31'b0, tc}, exp_tc);
        @(posedge clk);
        if (r) begin
            m_q   = 0;
            m_err = 0;
        end else if (l) begin
            m_err = (dv >= MOD) ? 1 : 0;
            m_q   = (dv >= MOD) ? 0 : dv;
        end else begin
            m_err = 0;
            if (e) m_q = u ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
        end
        #1;
        chk("q", {28'b0, q}, m_q);
        chk("qb", {28'b0, qb}, {28'b0, ~m_q[WIDTH-1:0]});
        chk("err", {31'b0, err}, m_err);
    endtask

    initial begin
        // reset with a competing load
        step(1, 1, 0, 0, 5);
        step(1, 1, 0, 0, 5);
        chk("rst_q", {28'b0, q}, 0);
        chk("rst_qb", {28'b0, qb}, 4'hF);

        // up-count across the wrap
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);
        chk("up_end_q", {28'b0, q}, 2);

        // down-count across the wrap
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        chk("dn_end_q", {28'b0, q}, 8);

        // hold
        step(0, 0, 0, 1, 3);
        chk("hold_q", {28'b0, q}, 8);

        // load beats count enable
        step(0, 1, 1, 1, 7);
        chk("ldpri_q", {28'b0, q}, 7);

        // out-of-range load, err lasts one cycle
        step(0, 1, 0, 0, 12);
        chk("oor_err", {31'b0, err}, 1);
        step(0, 0, 0, 0, 0);
        chk("oor_err_clr", {31'b0, err}, 0);
        step(0, 1, 0, 0, 15);
        step(0, 1, 0, 0, 9);

        // direction change every edge at the boundary
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);

        // reset mid-count
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 1, 0);
        chk("mid_q6", {28'b0, q}, 6);
        step(1, 0, 1, 1, 0);
        chk("mid_rst_q", {28'b0, q}, 0);
        step(0, 0, 1, 1, 0);
        chk("mid_resume_q", {28'b0, q}, 1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(31) == 0), ($urandom_range(5) == 0),
                 ($urandom_range(3) != 0), $urandom_range(1), int'($urandom_range(15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
